// File: rtl/axilite_m_arbiter.sv
// Round-robin arbiter/sequencer that shares one axilite_m command port between NUM_REQ requesters.
// Define AXIL_ARB_TIMEOUT_EN to enable the WAIT watchdog (TIMEOUT_CYCLES, reported on rsp_err).
module axilite_m_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      m_axi_aclk,
    input  logic                      m_axi_areset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*4-1:0]      req_wstrb,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      start_write,
    output logic                      start_read,
    output logic [ADDR_W-1:0]         write_addr,
    output logic [DATA_W-1:0]         write_data,
    output logic [3:0]                write_strb,
    output logic [ADDR_W-1:0]         read_addr,
    input  logic [DATA_W-1:0]         read_data,
    input  logic                      done
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("axilite_m_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("axilite_m_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]     owner_q, owner_d;
    logic                op_write_q, op_write_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                start_write_q, start_write_d;
    logic                start_read_q, start_read_d;
    logic [ADDR_W-1:0]   write_addr_q, write_addr_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic [3:0]          write_strb_q, write_strb_d;
    logic [ADDR_W-1:0]   read_addr_q, read_addr_d;
    logic [PtrW-1:0]     winner;
    logic                any_valid;
    logic                finish_txn;

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic                rsp_err_q, rsp_err_d;
    logic [CntW-1:0]     wait_cnt_q, wait_cnt_d;
`endif

    // Requester index k positions after base, modulo NUM_REQ.
    function automatic logic [PtrW-1:0] rr_idx(input logic [PtrW-1:0] base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        return PtrW'(s % NUM_REQ);
    endfunction

    // Walk the rotation backwards so the first valid requester from rr_ptr wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rr_idx(rr_ptr_q, k)]) begin
                winner    = rr_idx(rr_ptr_q, k);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        op_write_d    = op_write_q;
        req_ready_d   = '0;
        rsp_valid_d   = '0;
        rsp_rdata_d   = rsp_rdata_q;
        start_write_d = 1'b0;
        start_read_d  = 1'b0;
        write_addr_d  = write_addr_q;
        write_data_d  = write_data_q;
        write_strb_d  = write_strb_q;
        read_addr_d   = read_addr_q;
        finish_txn    = 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
        rsp_err_d     = rsp_err_q;
        wait_cnt_d    = wait_cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    owner_d             = winner;
                    op_write_d          = req_we[winner];
                    req_ready_d[winner] = 1'b1;
                    if (req_we[winner]) begin
                        write_addr_d  = req_addr[32'(winner)*ADDR_W +: ADDR_W];
                        write_data_d  = req_wdata[32'(winner)*DATA_W +: DATA_W];
                        write_strb_d  = req_wstrb[32'(winner)*4 +: 4];
                        start_write_d = 1'b1;
                    end else begin
                        read_addr_d   = req_addr[32'(winner)*ADDR_W +: ADDR_W];
                        start_read_d  = 1'b1;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
`ifdef AXIL_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (done) begin
                    finish_txn  = 1'b1;
                    rsp_rdata_d = op_write_q ? '0 : read_data;
`ifdef AXIL_ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                end
`ifdef AXIL_ARB_TIMEOUT_EN
                else if (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    finish_txn  = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
`endif
                if (finish_txn) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rr_ptr_d = (owner_q == PtrW'(NUM_REQ - 1)) ? '0 : owner_q + PtrW'(1);
                    state_d  = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            op_write_q    <= 1'b0;
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            start_write_q <= 1'b0;
            start_read_q  <= 1'b0;
            write_addr_q  <= '0;
            write_data_q  <= '0;
            write_strb_q  <= '0;
            read_addr_q   <= '0;
`ifdef AXIL_ARB_TIMEOUT_EN
            rsp_err_q     <= 1'b0;
            wait_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            op_write_q    <= op_write_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            start_write_q <= start_write_d;
            start_read_q  <= start_read_d;
            write_addr_q  <= write_addr_d;
            write_data_q  <= write_data_d;
            write_strb_q  <= write_strb_d;
            read_addr_q   <= read_addr_d;
`ifdef AXIL_ARB_TIMEOUT_EN
            rsp_err_q     <= rsp_err_d;
            wait_cnt_q    <= wait_cnt_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign start_write = start_write_q;
    assign start_read  = start_read_q;
    assign write_addr  = write_addr_q;
    assign write_data  = write_data_q;
    assign write_strb  = write_strb_q;
    assign read_addr   = read_addr_q;
`ifdef AXIL_ARB_TIMEOUT_EN
    assign rsp_err     = rsp_err_q;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_axilite_m_arbiter.sv
// Bench for axilite_m_arbiter: directed steps plus randomized traffic against a rotation model,
// with the bench acting as the axilite_m slave behind a byte-strobed memory.
module tb_axilite_m_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic              tb_m_axi_aclk = 1'b0;
    logic              m_axi_areset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_we;
    logic [N*32-1:0]   req_addr;
    logic [N*32-1:0]   req_wdata;
    logic [N*4-1:0]    req_wstrb;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              start_write;
    logic              start_read;
    logic [31:0]       write_addr;
    logic [31:0]       write_data;
    logic [3:0]        write_strb;
    logic [31:0]       read_addr;
    logic [31:0]       read_data;
    logic              done;

    always #5 tb_m_axi_aclk = ~tb_m_axi_aclk;

    axilite_m_arbiter #(
        .NUM_REQ(N), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .m_axi_aclk(tb_m_axi_aclk), .m_axi_areset(m_axi_areset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .start_write(start_write), .start_read(start_read), .write_addr(write_addr),
        .write_data(write_data), .write_strb(write_strb), .read_addr(read_addr),
        .read_data(read_data), .done(done)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit          pend [N];
    bit          we_m [N];
    logic [31:0] addr_m [N];
    logic [31:0] wdata_m [N];
    logic [3:0]  strb_m [N];
    int          rr;
    logic [31:0] mw_addr, mw_data, mr_addr;
    logic [3:0]  mw_strb;
    logic [31:0] mem [logic [31:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (pend[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = pend[i];
            req_we[i]              = we_m[i];
            req_addr[i*32 +: 32]   = addr_m[i];
            req_wdata[i*32 +: 32]  = wdata_m[i];
            req_wstrb[i*4 +: 4]    = strb_m[i];
        end
    endtask

    task automatic set_req(input int i, input bit we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        pend[i] = 1'b1; we_m[i] = we; addr_m[i] = a; wdata_m[i] = d; strb_m[i] = s;
        drive();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
        check({tag, "_start_write"}, 64'(start_write), 64'(0));
        check({tag, "_start_read"}, 64'(start_read), 64'(0));
        check({tag, "_write_addr"}, 64'(write_addr), 64'(0));
        check({tag, "_write_data"}, 64'(write_data), 64'(0));
        check({tag, "_write_strb"}, 64'(write_strb), 64'(0));
        check({tag, "_read_addr"}, 64'(read_addr), 64'(0));
    endtask

    task automatic do_reset();
        m_axi_areset = 1'b1;
        done = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
        repeat (5) @(negedge tb_m_axi_aclk);
        m_axi_areset = 1'b0;
        rr = 0; mw_addr = '0; mw_data = '0; mw_strb = '0; mr_addr = '0;
    endtask

    // Waits for the grant, checks ISSUE outputs, returns at the first WAIT-state negedge.
    task automatic grant_phase(input bit early_done, output int w);
        int n;
        w = pick();
        n = 0;
        @(negedge tb_m_axi_aclk);
        while (req_ready === '0 && n < 20) begin
            @(negedge tb_m_axi_aclk);
            n++;
        end
        check("grant", 64'(req_ready), 64'(1) << w);
        check("issue_start_write", 64'(start_write), 64'(we_m[w]));
        check("issue_start_read", 64'(start_read), 64'(!we_m[w]));
        if (we_m[w]) begin
            mw_addr = addr_m[w]; mw_data = wdata_m[w]; mw_strb = strb_m[w];
        end else begin
            mr_addr = addr_m[w];
        end
        check("write_addr", 64'(write_addr), 64'(mw_addr));
        check("write_data", 64'(write_data), 64'(mw_data));
        check("write_strb", 64'(write_strb), 64'(mw_strb));
        check("read_addr", 64'(read_addr), 64'(mr_addr));
        check("issue_no_rsp", 64'(rsp_valid), 64'(0));
        pend[w] = 1'b0;
        drive();
        if (early_done) done = 1'b1;
        @(negedge tb_m_axi_aclk);
        done = 1'b0;
        check("wait_start_write", 64'(start_write), 64'(0));
        check("wait_start_read", 64'(start_read), 64'(0));
        check("wait_req_ready", 64'(req_ready), 64'(0));
        check("wait_no_rsp", 64'(rsp_valid), 64'(0));
    endtask

    task automatic complete_phase(input int w, input int lat);
        logic [31:0] rd, exp_rd, old, mask;
        repeat (lat) @(negedge tb_m_axi_aclk);
        if (we_m[w]) begin
            old  = mem.exists(addr_m[w]) ? mem[addr_m[w]] : 32'h0;
            mask = {{8{strb_m[w][3]}}, {8{strb_m[w][2]}}, {8{strb_m[w][1]}}, {8{strb_m[w][0]}}};
            mem[addr_m[w]] = (old & ~mask) | (wdata_m[w] & mask);
            rd = $urandom;
            exp_rd = 32'h0;
        end else begin
            rd = mem.exists(addr_m[w]) ? mem[addr_m[w]] : $urandom;
            exp_rd = rd;
        end
        read_data = rd;
        done = 1'b1;
        @(negedge tb_m_axi_aclk);
        done = 1'b0;
        read_data = $urandom;
        check("rsp_valid", 64'(rsp_valid), 64'(1) << w);
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        check("rsp_err", 64'(rsp_err), 64'(0));
        check("rsp_no_ready", 64'(req_ready), 64'(0));
        rr = (w + 1) % N;
        @(negedge tb_m_axi_aclk);
        check("rsp_one_cycle", 64'(rsp_valid), 64'(0));
    endtask

    task automatic serve(input bit early_done, input int lat);
        int w;
        grant_phase(early_done, w);
        complete_phase(w, lat);
    endtask

    initial begin
        int w;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; we_m[i] = 0; addr_m[i] = '0; wdata_m[i] = '0; strb_m[i] = '0;
        end
        read_data = '0;
        done = 1'b0;
        m_axi_areset = 1'b1;
        drive();
        @(negedge tb_m_axi_aclk);
        check_zero("in_reset");
        do_reset();
        check_zero("after_reset");

        // Write from requester 0, then read it back from requester 1 (done also pulsed in ISSUE)
        set_req(0, 1'b1, 32'h30, 32'hC0DECAFE, 4'b1100);
        serve(1'b0, 2);
        set_req(1, 1'b0, 32'h30, 32'h0, 4'h0);
        serve(1'b1, 1);

        // done while idle must not produce a response
        done = 1'b1;
        repeat (3) begin
            @(negedge tb_m_axi_aclk);
            check("idle_done_ignored", 64'(rsp_valid), 64'(0));
        end
        done = 1'b0;

        // All four requesting from reset: strict rotation, then wrap 3 -> 0
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, i[0], 32'(i * 4), $urandom, 4'hF);
        for (int i = 0; i < N; i++) serve(1'b0, $urandom_range(0, 3));
        set_req(0, 1'b0, 32'h8, 32'h0, 4'h0);
        set_req(2, 1'b1, 32'h10, 32'h12345678, 4'b0101);
        serve(1'b0, 0);
        serve(1'b0, 0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            bit any;
            any = 0;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                            $urandom, 4'($urandom_range(0, 15)));
                any |= pend[i];
            end
            if (!any) set_req($urandom_range(0, N - 1), 1'b0, 32'h30, 32'h0, 4'h0);
            serve(1'b0, $urandom_range(0, 4));
        end
        while (pick() >= 0) serve(1'b0, $urandom_range(0, 2));

        // Reset mid-WAIT: abandon, then rotation restarts from requester 0
        set_req(2, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF);
        serve(1'b0, 0);
        set_req(1, 1'b0, 32'h24, 32'h0, 4'h0);
        grant_phase(1'b0, w);
        m_axi_areset = 1'b1;
        @(negedge tb_m_axi_aclk);
        m_axi_areset = 1'b0;
        rr = 0; mw_addr = '0; mw_data = '0; mw_strb = '0; mr_addr = '0;
        check_zero("mid_wait_reset");
        @(negedge tb_m_axi_aclk);
        check("abandoned_no_rsp", 64'(rsp_valid), 64'(0));
        set_req(2, 1'b0, 32'h20, 32'h0, 4'h0);
        set_req(3, 1'b0, 32'h24, 32'h0, 4'h0);
        serve(1'b0, 1);
        serve(1'b0, 1);

`ifdef AXIL_ARB_TIMEOUT_EN
        // Watchdog: no done -> error response TO cycles into WAIT; a late done is ignored
        set_req(1, 1'b0, 32'h3C, 32'h0, 4'h0);
        grant_phase(1'b0, w);
        repeat (TO - 1) begin
            @(negedge tb_m_axi_aclk);
            check("timeout_not_yet", 64'(rsp_valid), 64'(0));
        end
        @(negedge tb_m_axi_aclk);
        check("timeout_rsp_valid", 64'(rsp_valid), 64'(1) << w);
        check("timeout_rsp_err", 64'(rsp_err), 64'(1));
        check("timeout_rsp_rdata", 64'(rsp_rdata), 64'(0));
        rr = (w + 1) % N;
        repeat (4) @(negedge tb_m_axi_aclk);
        done = 1'b1;
        read_data = 32'hDEADBEEF;
        @(negedge tb_m_axi_aclk);
        done = 1'b0;
        repeat (2) begin
            @(negedge tb_m_axi_aclk);
            check("late_done_ignored", 64'(rsp_valid), 64'(0));
        end
        set_req(0, 1'b0, 32'h30, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h30, 32'h0, 4'h0);
        serve(1'b0, 0);
        serve(1'b0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
